// File: rtl/progdump_axi_if.sv
// AXI4-Lite read-only channel bundle between the dump engine and the memory
// interconnect. The engine never writes, so AW/W/B are deliberately absent.
interface progdump_axi_if #(
   parameter int MEM_ADDR_SIZE = 32,
   parameter int DATA_WIDTH    = 32
);
   logic [MEM_ADDR_SIZE-1:0] araddr;
   logic                     arvalid;
   logic                     arready;
   logic [DATA_WIDTH-1:0]    rdata;
   logic [1:0]               rresp;
   logic                     rvalid;
   logic                     rready;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/progdump_axi.sv
// Memory readback engine: on start, reads word_count words starting at
// base_addr over AXI4-Lite (one read outstanding at a time) and streams each
// word out of an 8N1 UART, least-significant byte first, bytes back-to-back.
module progdump_axi #(
   parameter int CLKS_PER_BIT  = 83,
   parameter int MEM_ADDR_SIZE = 32,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [MEM_ADDR_SIZE-1:0] base_addr,
   input  logic [15:0]              word_count,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   progdump_axi_if.master           axi,
   output logic                     utx
);
   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CNT_W-1:0]         CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0]        LAST_BYTE = BYTE_W'(BYTES - 1);
   localparam logic [MEM_ADDR_SIZE-1:0] ADDR_STEP = MEM_ADDR_SIZE'(BYTES);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, SEND, NEXT, FIN} state_t;

   state_t                   state_reg, state_next;
   logic [MEM_ADDR_SIZE-1:0] addr_reg;
   logic [15:0]              count_reg;
   logic [DATA_WIDTH-1:0]    shift_reg;
   logic [CNT_W-1:0]         clk_cnt_reg;
   logic [3:0]               bit_idx_reg;   // 0 start, 1..8 data, 9 stop
   logic [BYTE_W-1:0]        byte_idx_reg;
   logic                     err_reg;
   logic                     utx_reg;

   logic bit_end;
   logic word_end;

   assign bit_end  = (clk_cnt_reg == CNT_MAX);
   assign word_end = bit_end && (bit_idx_reg == 4'd9) && (byte_idx_reg == LAST_BYTE);

   // The address register drives the bus directly, so araddr cannot move
   // while arvalid is held waiting for arready.
   assign axi.araddr = addr_reg;
   assign err        = err_reg;
   assign utx        = utx_reg;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state decode and handshake/status outputs.
   always_comb begin
      state_next  = state_reg;
      busy        = 1'b0;
      done        = 1'b0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = (word_count == 16'd0) ? FIN : ADDR;
         end
         ADDR: begin
            busy        = 1'b1;
            axi.arvalid = 1'b1;
            if (axi.arready) state_next = DATA;
         end
         DATA: begin
            busy       = 1'b1;
            axi.rready = 1'b1;
            if (axi.rvalid) state_next = SEND;
         end
         SEND: begin
            busy = 1'b1;
            if (word_end) state_next = NEXT;
         end
         NEXT: begin
            busy       = 1'b1;
            state_next = (count_reg == 16'd1) ? FIN : ADDR;
         end
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: parameter latch, read capture, UART bit timing and address walk.
   // utx is registered and updated one edge ahead of each bit so the line is
   // glitch-free and the start bit appears the cycle after data capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg     <= '0;
         count_reg    <= '0;
         shift_reg    <= '0;
         clk_cnt_reg  <= '0;
         bit_idx_reg  <= '0;
         byte_idx_reg <= '0;
         err_reg      <= 1'b0;
         utx_reg      <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  addr_reg  <= base_addr;
                  count_reg <= word_count;
                  err_reg   <= 1'b0;
               end
            end
            DATA: begin
               if (axi.rvalid) begin
                  // Error responses still get their data dumped; err only flags it.
                  shift_reg    <= axi.rdata;
                  if (axi.rresp != 2'b00) err_reg <= 1'b1;
                  clk_cnt_reg  <= '0;
                  bit_idx_reg  <= '0;
                  byte_idx_reg <= '0;
                  utx_reg      <= 1'b0;
               end
            end
            SEND: begin
               if (!bit_end) begin
                  clk_cnt_reg <= clk_cnt_reg + 1'b1;
               end else begin
                  clk_cnt_reg <= '0;
                  if (bit_idx_reg == 4'd9) begin
                     bit_idx_reg <= '0;
                     if (byte_idx_reg == LAST_BYTE) begin
                        utx_reg <= 1'b1;
                     end else begin
                        // Next byte starts right after this stop bit, no idle gap.
                        byte_idx_reg <= byte_idx_reg + 1'b1;
                        shift_reg    <= shift_reg >> 8;
                        utx_reg      <= 1'b0;
                     end
                  end else if (bit_idx_reg == 4'd8) begin
                     bit_idx_reg <= 4'd9;
                     utx_reg     <= 1'b1;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 4'd1;
                     utx_reg     <= shift_reg[bit_idx_reg[2:0]];
                  end
               end
            end
            NEXT: begin
               addr_reg  <= addr_reg + ADDR_STEP;
               count_reg <= count_reg - 16'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_progdump_axi.sv
// Directed bench for progdump_axi: AXI read slave with programmable latency,
// negedge-sampling UART receiver, and monitors for AR stability and
// single-outstanding behaviour.
module tb_progdump_axi;
   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [15:0] word_count = '0;
   logic        busy, done, err, utx;

   progdump_axi_if #(.MEM_ADDR_SIZE(32), .DATA_WIDTH(32)) axi ();

   progdump_axi #(.CLKS_PER_BIT(CPB), .MEM_ADDR_SIZE(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .word_count(word_count), .busy(busy), .done(done), .err(err),
      .axi(axi.master), .utx(utx)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_1000: return 32'h4433_2211;
         32'h0000_2000: return 32'hA1B2_C3D4;
         32'h0000_2004: return 32'h0F1E_2D3C;
         32'h0000_2008: return 32'h80FF_7F01;
         32'hFFFF_FFFC: return 32'hDEAD_BEEF;
         32'h0000_0000: return 32'h1234_5678;
         default:       return 32'hBAD0_BAD0;
      endcase
   endfunction

   // AXI read slave plus protocol monitors (all at negedge)
   int          ar_delay = 0, r_delay = 0, ar_wait = 0, r_wait = 0;
   bit          r_pending = 0;
   logic [31:0] r_addr = '0;
   logic [31:0] bad_addr = 32'h1;
   logic [31:0] ar_q[$];
   bit          prev_arvalid = 0;
   logic [31:0] prev_araddr = '0;
   int          ar_unstable = 0, outstanding_viol = 0;

   always @(negedge clk) begin
      if (!rst && prev_arvalid && !axi.arready &&
          (!axi.arvalid || axi.araddr != prev_araddr)) ar_unstable++;
      if (!rst && axi.arvalid && r_pending) outstanding_viol++;
      prev_arvalid = axi.arvalid;
      prev_araddr  = axi.araddr;
      axi.arready  = 1'b0;
      axi.rvalid   = 1'b0;
      if (rst) begin
         ar_wait = 0; r_wait = 0; r_pending = 0; prev_arvalid = 0;
      end else if (axi.arvalid && !r_pending) begin
         if (ar_wait >= ar_delay) begin
            axi.arready = 1'b1;
            ar_q.push_back(axi.araddr);
            r_addr = axi.araddr; r_pending = 1; r_wait = 0; ar_wait = 0;
         end else ar_wait++;
      end else if (r_pending && axi.rready) begin
         if (r_wait >= r_delay) begin
            axi.rvalid = 1'b1;
            axi.rdata  = mem_word(r_addr);
            axi.rresp  = (r_addr == bad_addr) ? 2'b10 : 2'b00;
            r_pending  = 0;
         end else r_wait++;
      end
   end

   // UART receiver: each entry is {stop_bit, data_byte}; st_q holds start cycles
   bit         rx_act = 0;
   int         rx_n = 0;
   logic [8:0] rx_sh = '0;
   logic [8:0] rx_q[$];
   int         st_q[$];
   int         utx_low_cnt = 0;

   always @(negedge clk) begin
      if (utx !== 1'b1) utx_low_cnt++;
      if (rst) rx_act = 0;
      else if (!rx_act) begin
         if (utx == 1'b0) begin rx_act = 1; rx_n = 0; st_q.push_back(cyc); end
      end else begin
         rx_n++;
         if (rx_n >= CPB + CPB/2 && (rx_n - CPB/2) % CPB == 0)
            rx_sh[(rx_n - CPB/2)/CPB - 1] = utx;
         if (rx_n == 10*CPB - 1) begin rx_q.push_back(rx_sh); rx_act = 0; end
      end
   end

   // Completion monitor
   int   done_cnt = 0, done_cyc = 0;
   logic err_at_done = 1'b0;
   always @(negedge clk) begin
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; err_at_done = err; end
   end

   logic [31:0] exp_q[$];

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, output int c0);
      step(); start = 1'b1; base_addr = b; word_count = n;
      step(); start = 1'b0; c0 = cyc;
   endtask

   task automatic wait_done(input int target, input string tag);
      int k;
      k = 0;
      while (done_cnt < target && k < 3000) begin step(); k++; end
      check({tag, "_done_cnt"}, done_cnt, target);
   endtask

   task automatic clear_logs();
      ar_q.delete(); rx_q.delete(); st_q.delete();
   endtask

   task automatic check_bytes(input string tag);
      logic [31:0] wv;
      logic [8:0]  eb;
      int idx;
      check({tag, "_nbytes"}, rx_q.size(), exp_q.size() * 4);
      for (int i = 0; i < exp_q.size(); i++) begin
         wv = exp_q[i];
         for (int b = 0; b < 4; b++) begin
            idx = i*4 + b;
            eb  = {1'b1, wv[8*b +: 8]};
            if (idx < rx_q.size()) check($sformatf("%s_byte%0d", tag, idx), rx_q[idx], eb);
         end
      end
      $display("dump %s: %0d words, %0d bytes received", tag, ar_q.size(), rx_q.size());
   endtask

   task automatic check_gaps(input string tag);
      int gap_err;
      gap_err = 0;
      for (int i = 1; i < st_q.size(); i++)
         if (i % 4 != 0 && st_q[i] - st_q[i-1] != 10*CPB) gap_err++;
      check({tag, "_byte_gaps"}, gap_err, 0);
   endtask

   initial begin
      int c0, dummy, k;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_arvalid", axi.arvalid, 0);
      check("rst_rready", axi.rready, 0);
      check("rst_araddr", axi.araddr, 32'h0);
      check("rst_utx", utx, 1);
      rst = 1'b0;
      step();

      // T1: single word, immediate slave
      clear_logs();
      pulse_start(32'h1000, 16'd1, c0);
      check("t1_busy_t1", busy, 1);
      check("t1_arvalid_t1", axi.arvalid, 1);
      check("t1_araddr_t1", axi.araddr, 32'h1000);
      wait_done(1, "t1");
      check("t1_done_latency", done_cyc - c0, 163);
      check("t1_start_bit_latency", (st_q.size() > 0) ? st_q[0] - c0 : -1, 2);
      check("t1_ar_count", ar_q.size(), 1);
      if (ar_q.size() > 0) check("t1_araddr0", ar_q[0], 32'h1000);
      check("t1_err", err_at_done, 0);
      exp_q = '{32'h4433_2211};
      check_bytes("t1");
      check_gaps("t1");

      // T2: three words with slow AR and R channels
      clear_logs();
      ar_delay = 5; r_delay = 7;
      pulse_start(32'h2000, 16'd3, c0);
      wait_done(2, "t2");
      check("t2_ar_count", ar_q.size(), 3);
      if (ar_q.size() == 3) begin
         check("t2_araddr0", ar_q[0], 32'h2000);
         check("t2_araddr1", ar_q[1], 32'h2004);
         check("t2_araddr2", ar_q[2], 32'h2008);
      end
      exp_q = '{32'hA1B2_C3D4, 32'h0F1E_2D3C, 32'h80FF_7F01};
      check_bytes("t2");
      check_gaps("t2");
      check("t2_ar_stable", ar_unstable, 0);
      check("t2_one_outstanding", outstanding_viol, 0);
      ar_delay = 0; r_delay = 0;

      // T3: address wrap
      clear_logs();
      pulse_start(32'hFFFF_FFFC, 16'd2, c0);
      wait_done(3, "t3");
      check("t3_ar_count", ar_q.size(), 2);
      if (ar_q.size() == 2) begin
         check("t3_araddr0", ar_q[0], 32'hFFFF_FFFC);
         check("t3_araddr1_wrap", ar_q[1], 32'h0000_0000);
      end
      exp_q = '{32'hDEAD_BEEF, 32'h1234_5678};
      check_bytes("t3");

      // T4: error response on the middle word, then a clean dump clears err
      clear_logs();
      bad_addr = 32'h2004;
      pulse_start(32'h2000, 16'd3, c0);
      wait_done(4, "t4");
      check("t4_err_at_done", err_at_done, 1);
      exp_q = '{32'hA1B2_C3D4, 32'h0F1E_2D3C, 32'h80FF_7F01};
      check_bytes("t4");
      repeat (5) step();
      check("t4_err_sticky", err, 1);
      bad_addr = 32'h1;
      clear_logs();
      pulse_start(32'h1000, 16'd1, c0);
      check("t4b_err_cleared", err, 0);
      wait_done(5, "t4b");
      check("t4b_err_at_done", err_at_done, 0);

      // T5: zero-length dump
      clear_logs();
      repeat (3) step();
      utx_low_cnt = 0;
      pulse_start(32'h3000, 16'd0, c0);
      check("t5_done_t1", done, 1);
      check("t5_busy", busy, 0);
      repeat (20) step();
      check("t5_done_cnt", done_cnt, 6);
      check("t5_no_ar", ar_q.size(), 0);
      check("t5_utx_idle", utx_low_cnt, 0);

      // T5b: start while busy is ignored
      clear_logs();
      pulse_start(32'h1000, 16'd1, c0);
      repeat (10) step();
      pulse_start(32'h3000, 16'd5, dummy);
      wait_done(7, "t5b");
      repeat (200) step();
      check("t5b_done_once", done_cnt, 7);
      check("t5b_ar_count", ar_q.size(), 1);
      if (ar_q.size() > 0) check("t5b_araddr0", ar_q[0], 32'h1000);
      exp_q = '{32'h4433_2211};
      check_bytes("t5b");

      // T6: reset in the middle of the second byte
      clear_logs();
      pulse_start(32'h1000, 16'd1, c0);
      k = 0;
      while (rx_q.size() < 1 && k < 500) begin step(); k++; end
      check("t6_first_byte_seen", rx_q.size(), 1);
      repeat (8) step();
      check("t6_busy_before_rst", busy, 1);
      rst = 1'b1;
      step();
      check("t6_rst_utx", utx, 1);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_arvalid", axi.arvalid, 0);
      check("t6_rst_rready", axi.rready, 0);
      check("t6_rst_done", done, 0);
      rst = 1'b0;
      step();
      clear_logs();
      pulse_start(32'h2008, 16'd1, c0);
      wait_done(8, "t6");
      check("t6_ar_count", ar_q.size(), 1);
      exp_q = '{32'h80FF_7F01};
      check_bytes("t6");
      check("final_ar_stable", ar_unstable, 0);
      check("final_one_outstanding", outstanding_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end
endmodule
